// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared constants and types for the alarm clock time base
package aclk_pkg;

  localparam int ACLK_CLK_PER_SEC_DEF = 256;
  localparam int ACLK_SEC_PER_MIN_DEF = 60;

  typedef logic [3:0] aclk_digit_t;

endpackage

// File: rtl/aclk_mod_counter.sv
// rtl/aclk_mod_counter.sv - modulo-N counter with enable, synchronous clear and wrap flag
module aclk_mod_counter
  import aclk_pkg::*;
#(
  parameter int N = ACLK_SEC_PER_MIN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // A wrap cleared in the same cycle never happened, so clr masks the flag.
  assign wrap = en && !clr && (cnt == LAST);

  // Count 0 .. N-1 while enabled; clear wins over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aclk_timegen.sv
// rtl/aclk_timegen.sv - one_second / one_minute strobe generator (option: ACLK_TIMEGEN_FAST_WATCH_EN)
module aclk_timegen
  import aclk_pkg::*;
#(
  parameter int CLK_PER_SEC = ACLK_CLK_PER_SEC_DEF,
  parameter int SEC_PER_MIN = ACLK_SEC_PER_MIN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_count,
  input  logic fast_watch,
  output logic one_second,
  output logic one_minute
);

  logic second_event;
  logic minute_event;
  logic fast;
  logic sec_clr;
  logic next_minute;

`ifdef ACLK_TIMEGEN_FAST_WATCH_EN
  assign fast = fast_watch;
`else
  logic unused_fast_watch;
  assign unused_fast_watch = fast_watch;
  assign fast = 1'b0;
`endif

  // Fast-watch pins the seconds counter at 0, so a full minute follows its release.
  assign sec_clr     = reset_count | fast;
  assign next_minute = fast ? second_event : minute_event;

  aclk_mod_counter #(.N(CLK_PER_SEC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (reset_count),
    .wrap  (second_event)
  );

  aclk_mod_counter #(.N(SEC_PER_MIN)) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (second_event),
    .clr   (sec_clr),
    .wrap  (minute_event)
  );

  // Register the events into single-cycle strobes; reset_count already masks the events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else begin
      one_second <= second_event;
      one_minute <= next_minute;
    end
  end

endmodule

// File: tb/tb_aclk_timegen.sv
// tb/tb_aclk_timegen.sv - randomized model-checked bench for aclk_timegen (option: ACLK_TIMEGEN_FAST_WATCH_EN)
module tb_aclk_timegen;
  import aclk_pkg::*;

  localparam int CPS = 4;
  localparam int SPM = 3;
`ifdef ACLK_TIMEGEN_FAST_WATCH_EN
  localparam bit FW_EN = 1'b1;
`else
  localparam bit FW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_count = 1'b0;
  logic fast_watch = 1'b0;
  logic one_second;
  logic one_minute;

  logic reset_b = 1'b1;
  logic rc_b = 1'b0;
  logic fw_b = 1'b0;
  logic sec_b;
  logic min_b;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  int   m_edges = 0;
  int   m_secs = 0;
  logic m_sec = 1'b0;
  logic m_min = 1'b0;

  aclk_timegen #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM)) dut (
    .clk         (clk),
    .reset       (reset),
    .reset_count (reset_count),
    .fast_watch  (fast_watch),
    .one_second  (one_second),
    .one_minute  (one_minute)
  );

  aclk_timegen dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .reset_count (rc_b),
    .fast_watch  (fw_b),
    .one_second  (sec_b),
    .one_minute  (min_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reset_count = 1'b0;
    repeat (3) begin
      step();
      chk("reset_sec", one_second, 1'b0);
      chk("reset_min", one_minute, 1'b0);
    end
    reset = 1'b0;
  endtask

  // Reference: edges since the last realignment and seconds since the last minute point.
  always @(posedge clk or posedge reset) begin
    if (reset || reset_count) begin
      m_edges = 0;
      m_secs  = 0;
      m_sec   = 1'b0;
      m_min   = 1'b0;
    end else begin
      m_edges = m_edges + 1;
      m_sec   = ((m_edges % CPS) == 0);
      m_min   = 1'b0;
      if (FW_EN && fast_watch) begin
        m_secs = 0;
        m_min  = m_sec;
      end else if (m_sec) begin
        m_secs = m_secs + 1;
        m_min  = ((m_secs % SPM) == 0);
      end
    end
  end

  // Compare the DUT with the reference every cycle once it has been reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("one_second", one_second, m_sec);
      chk("one_minute", one_minute, m_min);
    end
  end

  initial begin
    int n_sec;
    int n_min;
    int min_edge;

    // Basic strobes, with literal pins on the model too.
    do_reset();
    cmp_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("basic_sec", one_second, (k % 4) == 0);
      chk("basic_min", one_minute, (k % 12) == 0);
      chk("model_sec", m_sec, (k % 4) == 0);
      chk("model_min", m_min, (k % 12) == 0);
    end

    // reset_count realign at edge 6.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      reset_count = (k == 6);
      step();
      if (k <= 6) chk("rc_sec", one_second, k == 4);
      else        chk("rc_sec", one_second, k == 10 || k == 14 || k == 18);
      chk("rc_min", one_minute, k == 18);
    end
    reset_count = 1'b0;

    // Fast-watch from reset release, dropped after edge 8.
    do_reset();
    fast_watch = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 9) fast_watch = 1'b0;
      step();
      chk("fw_sec", one_second, (k % 4) == 0);
      if (FW_EN) chk("fw_min", one_minute, k == 4 || k == 8 || k == 20);
      else       chk("fw_min", one_minute, k == 12 || k == 24);
    end
    fast_watch = 1'b0;

    // Asynchronous reset while one_second is high.
    do_reset();
    repeat (4) step();
    chk("pre_async_sec", one_second, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_sec", one_second, 1'b0);
    chk("async_min", one_minute, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_async_sec", one_second, (k % 4) == 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      reset_count = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) fast_watch = ~fast_watch;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        #1;
        chk("rand_async_sec", one_second, 1'b0);
        chk("rand_async_min", one_minute, 1'b0);
        step();
        reset = 1'b0;
      end
    end
    reset_count = 1'b0;
    fast_watch  = 1'b0;

    // Default parameters: one full minute.
    step();
    reset_b  = 1'b0;
    n_sec    = 0;
    n_min    = 0;
    min_edge = 0;
    for (int k = 1; k <= 15360; k++) begin
      step();
      if (sec_b) n_sec++;
      if (min_b) begin
        n_min++;
        min_edge = k;
      end
    end
    chk_int("def_seconds", n_sec, 60);
    chk_int("def_minutes", n_min, 1);
    chk_int("def_minute_edge", min_edge, 15360);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
